// File: rtl/s344_mult_sched_pkg.sv
// Shared types and constants for the s344 multiplier scheduler.
package s344_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Counter value at which the core reports a finished product.
    localparam logic [2:0] CT_READY = 3'b101;

    localparam int OPW  = 4;    // operand width
    localparam int PW   = 8;    // product width
    localparam int IDW  = 3;    // requester index width (up to 8 requesters)
    localparam int CTW  = 3;    // core step counter width
    localparam int NXTW = 15;   // total core state width

    // Field offsets inside the packed core state {CT, ACVQN, MRVQN, AX}.
    localparam int CT_LSB    = 12;
    localparam int ACVQN_LSB = 8;
    localparam int MRVQN_LSB = 4;
    localparam int AX_LSB    = 0;

endpackage

// File: rtl/s344_mult_sched_state_bank.sv
// Enabled flop bank holding the s344 core state {CT, ACVQN, MRVQN, AX}.
module s344_state_bank #(
    parameter int W = 15
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    // Load the core next-state word only when the scheduler lets the core step.
    always_ff @(posedge ck) begin
        if (rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/s344_mult_sched.sv
// Round-robin sequencer sharing one combinational s344 multiplier core among N requesters.
module s344_mult_sched
    import s344_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [OPW*N-1:0] req_a,
    input  logic [OPW*N-1:0] req_b,
    output logic [N-1:0]     gnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [PW-1:0]    rsp_p,
    output logic             rsp_err,
    output logic             busy,
    output logic             c_start,
    output logic [OPW-1:0]   c_a,
    output logic [OPW-1:0]   c_b,
    output logic [CTW-1:0]   c_ct,
    output logic [3:0]       c_acvqn,
    output logic [3:0]       c_mrvqn,
    output logic [3:0]       c_ax,
    input  logic [NXTW-1:0]  c_nxt,
    input  logic             c_ready,
    input  logic [PW-1:0]    c_p
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [TW-1:0]   cnt_reg;
    logic [OPW-1:0]  a_reg, b_reg;
    logic [PW-1:0]   p_reg;
    logic            err_reg;

    logic            pick_valid;
    logic [IDW-1:0]  pick_id;
    logic [3:0]      idx_w;
    logic [7:0]      req_pad;
    logic [OPW-1:0]  a_sl [8];
    logic [OPW-1:0]  b_sl [8];
    logic            timeout_hit;
    logic            bank_en;
    logic [NXTW-1:0] bank_q;

    // Pad requests and operand slices to 8 lanes so a 3-bit index always fits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            if (gi < N) begin : g_used
                assign req_pad[gi] = req[gi];
                assign a_sl[gi]    = req_a[gi*OPW +: OPW];
                assign b_sl[gi]    = req_b[gi*OPW +: OPW];
            end else begin : g_unused
                assign req_pad[gi] = 1'b0;
                assign a_sl[gi]    = '0;
                assign b_sl[gi]    = '0;
            end
        end
    endgenerate

    // Round-robin pick: scan from farthest to nearest so the first set request at/after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx_w      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_w = {1'b0, ptr_reg} + 4'(k);
            if (idx_w >= 4'(N)) begin
                idx_w = idx_w - 4'(N);
            end
            if (req_pad[idx_w[2:0]]) begin
                pick_valid = 1'b1;
                pick_id    = idx_w[2:0];
            end
        end
    end

    assign timeout_hit = (cnt_reg == TW'(TIMEOUT - 1));

    // Next-state logic; core READY takes priority over the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (|req) state_next = ARB;
            ARB:  state_next = pick_valid ? LOAD : IDLE;
            LOAD: state_next = RUN;
            RUN:  if (c_ready || timeout_hit) state_next = DONE;
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus operand, pointer, timeout and response registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ARB: begin
                    if (pick_valid) begin
                        a_reg   <= a_sl[pick_id];
                        b_reg   <= b_sl[pick_id];
                        id_reg  <= pick_id;
                        ptr_reg <= (pick_id == IDW'(N - 1)) ? '0 : pick_id + 3'd1;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (c_ready) begin
                        p_reg   <= c_p;
                        err_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        p_reg   <= '0;
                        err_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        err_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-hot grant pulse in ARB, suppressed while reset is asserted.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg == ARB) && pick_valid && !rst && (pick_id == IDW'(gi));
        end
    endgenerate

    // Core flops step in LOAD and RUN, but freeze on the edge where READY is seen.
    assign bank_en = (state_reg == LOAD) || ((state_reg == RUN) && !c_ready);

    s344_state_bank #(.W(NXTW)) u_bank (
        .ck  (ck),
        .rst (rst),
        .en  (bank_en),
        .d   (c_nxt),
        .q   (bank_q)
    );

    assign c_ct      = bank_q[CT_LSB +: CTW];
    assign c_acvqn   = bank_q[ACVQN_LSB +: 4];
    assign c_mrvqn   = bank_q[MRVQN_LSB +: 4];
    assign c_ax      = bank_q[AX_LSB +: 4];
    assign c_a       = a_reg;
    assign c_b       = b_reg;
    assign c_start   = (state_reg == LOAD) && !rst;
    assign busy      = (state_reg != IDLE) && !rst;
    assign rsp_valid = (state_reg == DONE) && !rst;
    assign rsp_id    = id_reg;
    assign rsp_p     = p_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_s344_mult_sched.sv
// Directed bench: scheduler plus a behavioural s344 shift-add core.
module tb_s344_mult_sched;
    import s344_sched_pkg::*;

    localparam int N       = 4;
    localparam int TIMEOUT = 15;

    logic             ck = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [OPW*N-1:0] req_a, req_b;
    logic [N-1:0]     gnt;
    logic             rsp_valid, rsp_ready, rsp_err, busy, c_start;
    logic [IDW-1:0]   rsp_id;
    logic [PW-1:0]    rsp_p;
    logic [OPW-1:0]   c_a, c_b;
    logic [CTW-1:0]   c_ct;
    logic [3:0]       c_acvqn, c_mrvqn, c_ax;
    logic [NXTW-1:0]  c_nxt;
    logic             c_ready, core_ready, force_low;
    logic [PW-1:0]    c_p;
    logic [4:0]       sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ck = ~ck;

    s344_mult_sched #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .ck(ck), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_err(rsp_err), .busy(busy),
        .c_start(c_start), .c_a(c_a), .c_b(c_b), .c_ct(c_ct),
        .c_acvqn(c_acvqn), .c_mrvqn(c_mrvqn), .c_ax(c_ax),
        .c_nxt(c_nxt), .c_ready(c_ready), .c_p(c_p)
    );

    // Behavioural core: START loads {acc=0, mr=B, ax=A}; four right-shift add steps; then CT parks at CT_READY.
    always_comb begin
        sum = {1'b0, c_acvqn} + (c_mrvqn[0] ? {1'b0, c_ax} : 5'd0);
        if (c_start)
            c_nxt = {3'd0, 4'd0, c_b, c_a};
        else if (c_ct < 3'd4)
            c_nxt = {c_ct + 3'd1, sum[4:1], sum[0], c_mrvqn[3:1], c_ax};
        else
            c_nxt = {CT_READY, c_acvqn, c_mrvqn, c_ax};
    end
    assign core_ready = (c_ct == CT_READY);
    assign c_ready    = core_ready & ~force_low;
    assign c_p        = {c_acvqn, c_mrvqn};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[id*OPW +: OPW] = a;
        req_b[id*OPW +: OPW] = b;
        req[id] = 1'b1;
    endtask

    // Waits (bounded) for RSP_VALID; drops each request bit the edge after its grant.
    task automatic await_rsp(output logic [7:0] p, output int rid, output logic err,
                             output int lat, output int gcnt, output logic [3:0] gvec);
        int  cyc;
        int  gidx;
        bit  done;
        cyc = 0; gidx = -1; done = 0;
        p = '0; rid = -1; err = 1'b0; lat = 0; gcnt = 0; gvec = '0;
        while (!done && cyc < 60) begin
            @(negedge ck);
            cyc++;
            if (gnt != '0) begin
                gcnt++;
                gvec = gnt;
                for (int i = 0; i < N; i++) if (gnt[i]) gidx = i;
            end
            if (rsp_valid) begin
                done = 1; p = rsp_p; rid = int'(rsp_id); err = rsp_err; lat = cyc;
            end else begin
                @(posedge ck);
                #1;
                if (gidx >= 0) req[gidx] = 1'b0;
            end
        end
        if (!done) check("await_timeout", 32'd0, 32'd1);
        $display("op id=%0d p=%02h err=%0d lat=%0d grants=%0d", rid, p, err, lat, gcnt);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(posedge ck);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge ck);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] p;
    logic       err;
    logic [3:0] gvec;
    int         rid, lat, gcnt, lat1;
    int         ord  [6] = '{0, 1, 2, 3, 0, 1};
    int         prod [4] = '{6, 12, 20, 30};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; force_low = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        rst = 1'b0;
        @(negedge ck);
        check("reset_outputs", {gnt, rsp_valid, rsp_id, rsp_p, rsp_err, busy, c_start}, 32'd0);
        check("reset_core", {c_ct, c_acvqn, c_mrvqn, c_ax, c_a, c_b}, 32'd0);
        @(posedge ck);
        #1;

        // 1: single op 7*9 on requester 0.
        issue(0, 4'h7, 4'h9);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t1_gnt_count", gcnt, 1);
        check("t1_gnt_vec", gvec, 4'b0001);
        check("t1_p", p, 8'h3F);
        check("t1_id", rid, 0);
        check("t1_err", err, 0);
        check("t1_latency", lat, 10);   // IDLE, ARB, LOAD, 6 RUN, DONE
        lat1 = lat;
        check("t1_L_le_timeout", (lat1 - 4 <= TIMEOUT), 1);
        accept();

        // 2: exhaustive operand sweep on requester 2.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(2, 4'(a), 4'(b));
                await_rsp(p, rid, err, lat, gcnt, gvec);
                check("t2_p", p, 32'(a * b));
                check("t2_latency", lat, lat1);
                accept();
            end
        end

        // 3: all four requesting, consumer always ready.
        pulse_rst();
        for (int i = 0; i < N; i++) begin
            req_a[i*OPW +: OPW] = 4'(i + 2);
            req_b[i*OPW +: OPW] = 4'(i + 3);
        end
        req = 4'b1111;
        rsp_ready = 1'b1;
        begin
            int g, r, cyc, last_rsp;
            g = 0; r = 0; cyc = 0; last_rsp = 0;
            while (r < 6 && cyc < 200) begin
                @(negedge ck);
                cyc++;
                if (gnt != '0 && g < 6) begin
                    check("t3_onehot", 32'($onehot(gnt)), 1);
                    check("t3_gnt_order", gnt, 32'(1) << ord[g]);
                    if (g > 0) check("t3_b2b_gap", cyc - last_rsp, 2);
                    g++;
                end
                if (rsp_valid) begin
                    check("t3_rsp_id", rsp_id, ord[r]);
                    check("t3_rsp_p", rsp_p, prod[ord[r]]);
                    $display("op id=%0d p=%02h err=%0d", rsp_id, rsp_p, rsp_err);
                    last_rsp = cyc;
                    r++;
                end
            end
            if (r < 6) check("t3_timeout", 32'd0, 32'd1);
        end
        @(posedge ck);
        #1;
        req = '0;
        rsp_ready = 1'b0;
        @(negedge ck);
        check("t3_idle_after", busy, 0);
        @(posedge ck);
        #1;

        // 4: consumer stalls for 10 cycles while another request waits.
        issue(1, 4'h5, 4'h3);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t4_p", p, 8'h0F);
        issue(2, 4'h2, 4'h8);
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_p", rsp_p, 8'h0F);
            check("t4_hold_gnt", gnt, 0);
            check("t4_hold_ct", c_ct, CT_READY);
        end
        accept();
        @(negedge ck);
        check("t4_idle", busy, 0);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t4_pending_id", rid, 2);
        check("t4_pending_p", p, 8'h10);
        accept();

        // 5: reset in RUN with pointer at 2.
        issue(1, 4'h3, 4'h3);
        begin
            int cyc;
            cyc = 0;
            while (gnt[1] !== 1'b1 && cyc < 20) begin
                @(negedge ck);
                cyc++;
            end
            check("t5_gnt_seen", gnt[1], 1);
        end
        @(posedge ck); #1; req[1] = 1'b0;   // LOAD
        @(posedge ck);                      // RUN, step 1
        @(posedge ck); #1;                  // RUN, step 2
        check("t5_run_ct", c_ct, 1);
        check("t5_run_busy", busy, 1);
        rst = 1'b1;
        @(negedge ck);
        check("t5_rst_valid", rsp_valid, 0);
        @(posedge ck); #1;
        rst = 1'b0;
        @(negedge ck);
        check("t5_busy", busy, 0);
        check("t5_valid", rsp_valid, 0);
        check("t5_ct", c_ct, 0);
        @(posedge ck); #1;
        issue(3, 4'h1, 4'h1);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t5_p", p, 8'h01);
        check("t5_id", rid, 3);
        accept();
        // Pointer reset: leave it at 2, reset, then 1 and 3 compete -> 1 first.
        issue(1, 4'h2, 4'h2);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t5b_p", p, 8'h04);
        accept();
        pulse_rst();
        issue(1, 4'h2, 4'h5);
        issue(3, 4'h3, 4'h3);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t5b_first_id", rid, 1);
        check("t5b_first_p", p, 8'h0A);
        accept();
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t5b_second_id", rid, 3);
        check("t5b_second_p", p, 8'h09);
        accept();

        // 6: core never ready -> timeout abort, then a normal op.
        force_low = 1'b1;
        issue(0, 4'h6, 4'h7);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t6_err", err, 1);
        check("t6_p", p, 0);
        check("t6_latency", lat, 4 + TIMEOUT);
        accept();
        force_low = 1'b0;
        issue(0, 4'h6, 4'h7);
        await_rsp(p, rid, err, lat, gcnt, gvec);
        check("t6_after_err", err, 0);
        check("t6_after_p", p, 8'h2A);
        accept();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
